// File: rtl/axi_ddr_wr_master.sv
// axi_ddr_wr_master
//   Single-beat AXI4 write master. Each accepted 256-bit word becomes one
//   write (AWLEN=0, 32-byte beat) to BASE_ADDR + 32*idx. idx walks a ring of
//   REGION_WORDS words. Only one transaction is ever outstanding.
//
//   Optional feature: define AXI_WR_ERR_HALT_EN to park the block in a HALT
//   state after a non-OKAY write response, until reset.
//
// Ports
//   axi_clk, rst              clock, asynchronous active-high reset
//   i_data/i_valid/o_ready    upstream word handshake
//   m_aw*                     AXI4 write-address channel
//   m_w*                      AXI4 write-data channel
//   m_b*                      AXI4 write-response channel
//   o_busy                    a transaction is in flight (state not IDLE)
//   o_wr_cnt                  B responses received (wraps at 16 bits)
//   o_err_cnt                 non-OKAY B responses (saturates at 255)
module axi_ddr_wr_master #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          REGION_WORDS = 1024
) (
    input  logic         axi_clk,
    input  logic         rst,
    input  logic [255:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [31:0]  m_awaddr,
    output logic [7:0]   m_awlen,
    output logic [2:0]   m_awsize,
    output logic [1:0]   m_awburst,
    output logic         m_awvalid,
    input  logic         m_awready,
    output logic [255:0] m_wdata,
    output logic [31:0]  m_wstrb,
    output logic         m_wlast,
    output logic         m_wvalid,
    input  logic         m_wready,
    input  logic [1:0]   m_bresp,
    input  logic         m_bvalid,
    output logic         m_bready,
    output logic         o_busy,
    output logic [15:0]  o_wr_cnt,
    output logic [7:0]   o_err_cnt
);

`ifdef AXI_WR_ERR_HALT_EN
    typedef enum logic [1:0] {IDLE, SEND, RESP, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
`endif

    state_t      state;
    logic [15:0] idx;
    logic        accept;
    logic        aw_fin;
    logic        w_fin;
    logic        b_hs;
    logic        b_err;

    assign m_awlen   = 8'd0;
    assign m_awsize  = 3'b101;
    assign m_awburst = 2'b01;
    assign m_wstrb   = '1;
    assign m_wlast   = 1'b1;

    // State is forced to IDLE by reset, so only o_ready needs the extra gate
    // to stay low while rst is held.
    assign o_ready  = (state == IDLE) && !rst;
    assign o_busy   = (state != IDLE);
    assign m_bready = (state == RESP);

    assign accept = i_valid && o_ready;
    // A channel is finished if its valid already dropped or it handshakes now.
    assign aw_fin = !m_awvalid || m_awready;
    assign w_fin  = !m_wvalid  || m_wready;
    assign b_hs   = (state == RESP) && m_bvalid;
    assign b_err  = (m_bresp != 2'b00);

    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 16'd0;
            o_wr_cnt  <= 16'd0;
            o_err_cnt <= 8'd0;
            m_awaddr  <= BASE_ADDR;
            m_wdata   <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_wdata   <= i_data;
                        m_awaddr  <= BASE_ADDR + {11'd0, idx, 5'd0};
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (m_awready) m_awvalid <= 1'b0;
                    if (m_wready)  m_wvalid  <= 1'b0;
                    if (aw_fin && w_fin) state <= RESP;
                end
                RESP: begin
                    if (b_hs) begin
                        o_wr_cnt <= o_wr_cnt + 16'd1;
                        idx      <= (idx == 16'(REGION_WORDS - 1)) ? 16'd0 : idx + 16'd1;
                        if (b_err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
`ifdef AXI_WR_ERR_HALT_EN
                        state <= b_err ? HALT : IDLE;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef AXI_WR_ERR_HALT_EN
                HALT: state <= HALT;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ddr_wr_master.sv
// Randomized self-checking bench for axi_ddr_wr_master. A slave model drives
// AW/W readiness and B responses with chosen delays; a small reference model
// (ring index, write count, error count, halt flag) predicts every output.
module tb_axi_ddr_wr_master;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          RW   = 4;

    logic         axi_clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] i_data = '0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [31:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic [2:0]   m_awsize;
    logic [1:0]   m_awburst;
    logic         m_awvalid;
    logic         m_awready = 1'b0;
    logic [255:0] m_wdata;
    logic [31:0]  m_wstrb;
    logic         m_wlast;
    logic         m_wvalid;
    logic         m_wready = 1'b0;
    logic [1:0]   m_bresp = 2'b00;
    logic         m_bvalid = 1'b0;
    logic         m_bready;
    logic         o_busy;
    logic [15:0]  o_wr_cnt;
    logic [7:0]   o_err_cnt;

    axi_ddr_wr_master #(.BASE_ADDR(BASE), .REGION_WORDS(RW)) dut (
        .axi_clk(axi_clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .o_busy(o_busy), .o_wr_cnt(o_wr_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 axi_clk = ~axi_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int idx_m = 0;
    int wr_m  = 0;
    int err_m = 0;
    bit halted_m = 0;
`ifdef AXI_WR_ERR_HALT_EN
    localparam bit HALT_BUILD = 1'b1;
`else
    localparam bit HALT_BUILD = 1'b0;
`endif

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int i);
        return BASE + 32'(32 * i);
    endfunction

    task automatic model_reset();
        idx_m = 0; wr_m = 0; err_m = 0; halted_m = 0;
    endtask

    // One complete write, called at a negedge. AW/W readies rise aw_d/w_d
    // cycles into SEND, bvalid rises b_d cycles into RESP. With hold=1,
    // i_valid stays high after acceptance and i_data moves to next_d.
    task automatic do_write(input logic [255:0] d, input int aw_d, input int w_d,
                            input int b_d, input logic [1:0] br, input bit hold,
                            input logic [255:0] next_d, input bit expect_accept);
        bit acc = 0;
        bit aw_done = 0, w_done = 0;
        int k = 0;
        logic [31:0] ea;
        i_data  = d;
        i_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (o_ready) begin acc = 1; break; end
            @(negedge axi_clk);
        end
        if (!expect_accept) begin
            chk("not_accepted", {255'd0, acc}, 256'd0);
            i_valid = 1'b0;
            return;
        end
        if (!acc) begin
            chk("accept_timeout", 256'd0, 256'd1);
            i_valid = 1'b0;
            return;
        end
        ea = exp_addr(idx_m);
        @(negedge axi_clk);
        if (hold) i_data = next_d; else i_valid = 1'b0;
        // SEND: stray bvalid here must be ignored
        while (!(aw_done && w_done) && k < 40) begin
            chk("send_bready", {255'd0, m_bready}, 256'd0);
            chk("send_ready", {255'd0, o_ready}, 256'd0);
            chk("send_busy", {255'd0, o_busy}, 256'd1);
            chk("awvalid", {255'd0, m_awvalid}, {255'd0, !aw_done});
            chk("wvalid", {255'd0, m_wvalid}, {255'd0, !w_done});
            if (m_awvalid) chk("awaddr", {224'd0, m_awaddr}, {224'd0, ea});
            if (m_wvalid)  chk("wdata", m_wdata, d);
            m_awready = !aw_done && (k >= aw_d);
            m_wready  = !w_done && (k >= w_d);
            m_bvalid  = 1'($urandom_range(0, 1));
            m_bresp   = 2'b10;
            if (m_awready) aw_done = 1;
            if (m_wready)  w_done = 1;
            k++;
            @(negedge axi_clk);
        end
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        chk("resp_entry_bready", {255'd0, m_bready}, 256'd1);
        chk("resp_valids_low", {254'd0, m_awvalid, m_wvalid}, 256'd0);
        chk("stray_b_wrcnt", {240'd0, o_wr_cnt}, 256'(wr_m));
        for (int j = 0; j < b_d; j++) begin
            @(negedge axi_clk);
            chk("resp_wait_bready", {255'd0, m_bready}, 256'd1);
            chk("resp_wait_ready", {255'd0, o_ready}, 256'd0);
        end
        m_bvalid = 1'b1; m_bresp = br;
        @(negedge axi_clk);
        m_bvalid = 1'b0; m_bresp = 2'b00;
        // Reference model update from the rules, with plain arithmetic
        wr_m  = (wr_m + 1) % 65536;
        idx_m = (idx_m + 1) % RW;
        if (br != 2'b00) begin
            if (err_m < 255) err_m++;
            if (HALT_BUILD) halted_m = 1;
        end
        chk("wr_cnt", {240'd0, o_wr_cnt}, 256'(wr_m));
        chk("err_cnt", {248'd0, o_err_cnt}, 256'(err_m));
        chk("done_ready", {255'd0, o_ready}, {255'd0, !halted_m});
        chk("done_busy", {255'd0, o_busy}, {255'd0, halted_m});
        chk("done_bready", {255'd0, m_bready}, 256'd0);
    endtask

    task automatic apply_reset();
        @(negedge axi_clk);
        rst = 1'b1;
        #1;
        chk("rst_awvalid", {255'd0, m_awvalid}, 256'd0);
        chk("rst_wvalid", {255'd0, m_wvalid}, 256'd0);
        chk("rst_bready", {255'd0, m_bready}, 256'd0);
        chk("rst_busy", {255'd0, o_busy}, 256'd0);
        chk("rst_ready", {255'd0, o_ready}, 256'd0);
        chk("rst_wdata", m_wdata, 256'd0);
        chk("rst_awaddr", {224'd0, m_awaddr}, {224'd0, BASE});
        chk("rst_wrcnt", {240'd0, o_wr_cnt}, 256'd0);
        chk("rst_errcnt", {248'd0, o_err_cnt}, 256'd0);
        model_reset();
        @(negedge axi_clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {255'd0, o_ready}, 256'd1);
        @(negedge axi_clk);
    endtask

    initial begin
        logic [255:0] a5, w0, w1, w2;
        a5 = {32{8'hA5}};
        repeat (3) @(negedge axi_clk);
        apply_reset();

        chk("awlen", {248'd0, m_awlen}, 256'd0);
        chk("awsize", {253'd0, m_awsize}, 256'd5);
        chk("awburst", {254'd0, m_awburst}, 256'd1);
        chk("wstrb", {224'd0, m_wstrb}, {224'd0, 32'hFFFF_FFFF});
        chk("wlast", {255'd0, m_wlast}, 256'd1);

        // Single write, minimum latency: IDLE again in cycle 4
        do_write(a5, 0, 0, 1, 2'b00, 0, '0, 1);
        // Four more: addresses wrap back to BASE on the fifth
        for (int n = 1; n < 5; n++)
            do_write(256'(n) * 256'h1111, 0, 0, 0, 2'b00, 0, '0, 1);
        chk("wrap_wrcnt", {240'd0, o_wr_cnt}, 256'd5);

        // Skewed channels, both orders
        do_write({8{32'hDEAD_0001}}, 3, 0, 0, 2'b00, 0, '0, 1);
        do_write({8{32'hDEAD_0002}}, 0, 3, 2, 2'b00, 0, '0, 1);
        do_write({8{32'hDEAD_0003}}, 2, 2, 0, 2'b00, 0, '0, 1);

        // Backpressure: i_valid held across three distinct words
        w0 = {8{32'hB0B0_0000}}; w1 = {8{32'hB1B1_1111}}; w2 = {8{32'hB2B2_2222}};
        do_write(w0, 0, 0, 5, 2'b00, 1, w1, 1);
        do_write(w1, 0, 0, 5, 2'b00, 1, w2, 1);
        do_write(w2, 0, 0, 5, 2'b00, 0, '0, 1);

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            logic [255:0] d;
            logic [1:0] br;
            for (int q = 0; q < 8; q++) d[q*32 +: 32] = $urandom;
            br = HALT_BUILD ? 2'b00 : (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            do_write(d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), br, 0, '0, 1);
        end

        // Error response on the second of three writes
        apply_reset();
        do_write({8{32'hE000_0001}}, 0, 0, 0, 2'b00, 0, '0, 1);
        do_write({8{32'hE000_0002}}, 1, 0, 0, 2'b10, 0, '0, 1);
        do_write({8{32'hE000_0003}}, 0, 1, 0, 2'b00, 0, '0, !HALT_BUILD);
        chk("errtest_wrcnt", {240'd0, o_wr_cnt}, HALT_BUILD ? 256'd2 : 256'd3);
        chk("errtest_errcnt", {248'd0, o_err_cnt}, 256'd1);

        // Mid-transaction reset while AW is still pending
        apply_reset();
        do_write({8{32'h5555_0001}}, 0, 0, 0, 2'b01, 0, '0, 1);
        i_data = {8{32'h7777_0000}};
        i_valid = 1'b1;
        @(negedge axi_clk);
        i_valid = 1'b0;
        @(negedge axi_clk);
        chk("mid_awvalid_before", {255'd0, m_awvalid}, 256'd1);
        rst = 1'b1;
        #1;
        chk("mid_valids_low", {253'd0, m_awvalid, m_wvalid, m_bready}, 256'd0);
        chk("mid_wrcnt", {240'd0, o_wr_cnt}, 256'd0);
        chk("mid_errcnt", {248'd0, o_err_cnt}, 256'd0);
        model_reset();
        @(negedge axi_clk);
        rst = 1'b0;
        #1;
        chk("mid_post_ready", {255'd0, o_ready}, 256'd1);
        @(negedge axi_clk);
        chk("mid_post_busy", {255'd0, o_busy}, 256'd0);
        do_write({8{32'h9999_0001}}, 1, 1, 1, 2'b00, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
